// File: rtl/tournament_predictor_q.sv
// Tournament (local/global/meta) branch predictor with speculative global history,
// an in-flight prediction queue resolved in order, and a post-reset table-clear sweep.
module tournament_predictor_q #(
  parameter int IP_W            = 16,
  parameter int LOCAL_HIST_LEN  = 6,
  parameter int LOCAL_HIST_IDX  = 10,
  parameter int LOCAL_BIT_IDX   = 5,
  parameter int GLOBAL_HIST_LEN = 12,
  parameter int GLOBAL_BIT_IDX  = 10,
  parameter int META_BIT_IDX    = 10,
  parameter int CTR_W           = 2,
  parameter int INFLIGHT        = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET_N,
  input  logic                        fetch_valid,
  input  logic [IP_W-1:0]             IP_f,
  output logic                        prediction,
  output logic                        fetch_stall,
  input  logic                        resolve_valid,
  input  logic                        resolve_didJump,
  input  logic                        flush,
  output logic                        mispredict,
  output logic                        ready,
  output logic [$clog2(INFLIGHT):0]   count,
  output logic                        resolve_err
);
  localparam int LCI = LOCAL_BIT_IDX + LOCAL_HIST_LEN;
  localparam int K0  = (LOCAL_HIST_IDX > LCI) ? LOCAL_HIST_IDX : LCI;
  localparam int K1  = (K0 > GLOBAL_BIT_IDX) ? K0 : GLOBAL_BIT_IDX;
  localparam int K   = (K1 > META_BIT_IDX) ? K1 : META_BIT_IDX;
  localparam int PW  = $clog2(INFLIGHT);
  localparam int CW  = PW + 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W-1)) - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef struct packed {
    logic [IP_W-1:0]            ip;
    logic                       pl;
    logic                       pg;
    logic                       pred;
    logic [GLOBAL_HIST_LEN-1:0] ghr;
  } entry_t;

  logic [CTR_W-1:0]          lctr [2**LCI];
  logic [CTR_W-1:0]          gctr [2**GLOBAL_BIT_IDX];
  logic [CTR_W-1:0]          mctr [2**META_BIT_IDX];
  logic [LOCAL_HIST_LEN-1:0] lht  [2**LOCAL_HIST_IDX];
  entry_t                    qmem [INFLIGHT];

  state_t state_q, state_d;
  logic [K-1:0] idx_q, idx_d;
  logic [GLOBAL_HIST_LEN-1:0] spec_ghr_q, spec_ghr_d, com_ghr_q, com_ghr_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mis_q, mis_d, err_q, err_d, ready_q, ready_d;

  function automatic logic [CTR_W-1:0] sat(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (&c) ? c : c + 1'b1;
    return (|c) ? c - 1'b1 : c;
  endfunction

  // Fetch-side lookup
  logic [LOCAL_HIST_LEN-1:0] lht_f;
  logic [LCI-1:0]            lidx_f;
  logic [GLOBAL_BIT_IDX-1:0] gidx_f;
  logic pl_f, pg_f, pm_f;
  assign lht_f      = lht[IP_f[LOCAL_HIST_IDX-1:0]];
  assign lidx_f     = {IP_f[LOCAL_BIT_IDX-1:0], lht_f};
  assign gidx_f     = IP_f[GLOBAL_BIT_IDX-1:0] ^ spec_ghr_q[GLOBAL_BIT_IDX-1:0];
  assign pl_f       = lctr[lidx_f][CTR_W-1];
  assign pg_f       = gctr[gidx_f][CTR_W-1];
  assign pm_f       = mctr[IP_f[META_BIT_IDX-1:0]][CTR_W-1];
  assign prediction = pm_f ? pg_f : pl_f;

  // Resolve-side lookup; local index uses the LHT entry as it stands now
  entry_t head;
  logic [LOCAL_HIST_LEN-1:0] lht_h;
  logic [LCI-1:0]            lidx_h;
  logic [GLOBAL_BIT_IDX-1:0] gidx_h;
  logic [META_BIT_IDX-1:0]   midx_h;
  assign head   = qmem[head_q];
  assign lht_h  = lht[head.ip[LOCAL_HIST_IDX-1:0]];
  assign lidx_h = {head.ip[LOCAL_BIT_IDX-1:0], lht_h};
  assign gidx_h = head.ip[GLOBAL_BIT_IDX-1:0] ^ head.ghr[GLOBAL_BIT_IDX-1:0];
  assign midx_h = head.ip[META_BIT_IDX-1:0];

  logic run, do_res, mis, do_flush, clr, push;
  assign run         = (state_q == S_RUN);
  assign fetch_stall = !ready_q || (cnt_q == CW'(INFLIGHT));
  assign do_res      = run && resolve_valid && (cnt_q != '0);
  assign mis         = do_res && (resolve_didJump != head.pred);
  assign do_flush    = run && flush;
  assign clr         = mis || do_flush;
  assign push        = run && fetch_valid && !fetch_stall && !clr;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ready_d    = ready_q;
    com_ghr_d  = do_res ? {com_ghr_q[GLOBAL_HIST_LEN-2:0], resolve_didJump} : com_ghr_q;
    spec_ghr_d = spec_ghr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    mis_d      = mis;
    err_d      = run && resolve_valid && (cnt_q == '0);
    if (state_q == S_INIT) begin
      idx_d = idx_q + 1'b1;
      if (&idx_q) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end
    end
    // Repair takes the post-resolve committed history
    if (clr) begin
      spec_ghr_d = com_ghr_d;
      head_d     = '0;
      tail_d     = '0;
      cnt_d      = '0;
    end else begin
      if (push) spec_ghr_d = {spec_ghr_q[GLOBAL_HIST_LEN-2:0], prediction};
      head_d = head_q + PW'(do_res);
      tail_d = tail_q + PW'(push);
      cnt_d  = cnt_q + CW'(push) - CW'(do_res);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_INIT;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      spec_ghr_q <= '0;
      com_ghr_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      spec_ghr_q <= spec_ghr_d;
      com_ghr_q  <= com_ghr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  // Tables carry no reset; the sweep clears them before RUN
  always_ff @(posedge CLOCK_50) begin
    if (state_q == S_INIT) begin
      if (int'(idx_q) < (1 << LCI))            lctr[idx_q[LCI-1:0]]            <= CTR_INIT;
      if (int'(idx_q) < (1 << GLOBAL_BIT_IDX)) gctr[idx_q[GLOBAL_BIT_IDX-1:0]] <= CTR_INIT;
      if (int'(idx_q) < (1 << META_BIT_IDX))   mctr[idx_q[META_BIT_IDX-1:0]]   <= CTR_INIT;
      if (int'(idx_q) < (1 << LOCAL_HIST_IDX)) lht[idx_q[LOCAL_HIST_IDX-1:0]]  <= '0;
    end else if (do_res) begin
      lctr[lidx_h] <= sat(lctr[lidx_h], resolve_didJump);
      gctr[gidx_h] <= sat(gctr[gidx_h], resolve_didJump);
      if (head.pl != head.pg) mctr[midx_h] <= sat(mctr[midx_h], head.pg == resolve_didJump);
      lht[head.ip[LOCAL_HIST_IDX-1:0]] <= {lht_h[LOCAL_HIST_LEN-2:0], resolve_didJump};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) qmem[tail_q] <= '{ip: IP_f, pl: pl_f, pg: pg_f, pred: prediction, ghr: spec_ghr_q};
  end

  logic unused_bits;
  assign unused_bits = ^{IP_f, head.ip, head.ghr, spec_ghr_q};

  assign mispredict  = mis_q;
  assign resolve_err = err_q;
  assign ready       = ready_q;
  assign count       = cnt_q;
endmodule

// File: tb/tb_tournament_predictor_q.sv
// Directed bench for tournament_predictor_q at default parameters (K=11, CTR_W=2, INFLIGHT=4).
module tb_tournament_predictor_q;
  logic CLOCK_50 = 1'b0;
  logic RESET_N, fetch_valid, resolve_valid, resolve_didJump, flush;
  logic [15:0] IP_f;
  logic prediction, fetch_stall, mispredict, ready, resolve_err;
  logic [2:0] count;
  int checks = 0, errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  tournament_predictor_q dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .fetch_valid(fetch_valid), .IP_f(IP_f),
    .prediction(prediction), .fetch_stall(fetch_stall), .resolve_valid(resolve_valid),
    .resolve_didJump(resolve_didJump), .flush(flush), .mispredict(mispredict),
    .ready(ready), .count(count), .resolve_err(resolve_err));

  task automatic tick(); @(posedge CLOCK_50); #1; endtask

  task automatic idle();
    fetch_valid = 0; resolve_valid = 0; resolve_didJump = 0; flush = 0; IP_f = '0;
  endtask

  task automatic init_wait(output int n);
    n = 0;
    while (!ready && n < 5000) begin tick(); n++; end
  endtask

  task automatic reset_init();
    int n;
    idle(); RESET_N = 0; tick(); RESET_N = 1;
    init_wait(n);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_ready: got %b want 1", ready); end
  endtask

  task automatic test_reset();
    int n;
    logic [15:0] ips [4] = '{16'h0000, 16'h1234, 16'hFFFF, 16'h0040};
    idle(); RESET_N = 0; #3;
    checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    checks++; if (count !== 3'd0)       begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (mispredict !== 1'b0)  begin errors++; $display("FAIL rst_mispredict: got %b want 0", mispredict); end
    checks++; if (resolve_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", resolve_err); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", fetch_stall); end
    RESET_N = 1;
    init_wait(n);
    checks++; if (n != 2048) begin errors++; $display("FAIL init_cycles: got %0d want 2048", n); end
    foreach (ips[i]) begin
      IP_f = ips[i]; #1;
      checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL post_init_pred ip=%h: got %b want 0", ips[i], prediction); end
    end
    checks++; if (count !== 3'd0)       begin errors++; $display("FAIL post_init_count: got %0d want 0", count); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL post_init_stall: got %b want 0", fetch_stall); end
    idle();
  endtask

  task automatic test_reset_mid_init();
    int n;
    idle(); RESET_N = 0; tick(); RESET_N = 1;
    fetch_valid = 1; resolve_valid = 1; resolve_didJump = 1; IP_f = 16'h0040;
    for (int i = 0; i < 100; i++) begin flush = i[0]; tick(); end
    checks++; if (count !== 3'd0)       begin errors++; $display("FAIL init_ignore_count: got %0d want 0", count); end
    checks++; if (resolve_err !== 1'b0) begin errors++; $display("FAIL init_ignore_err: got %b want 0", resolve_err); end
    checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL init_ready_early: got %b want 0", ready); end
    idle();
    #2 RESET_N = 0; #2 RESET_N = 1;
    init_wait(n);
    checks++; if (n != 2048) begin errors++; $display("FAIL restart_cycles: got %0d want 2048", n); end
    IP_f = 16'h0040; #1;
    checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL restart_pred: got %b want 0", prediction); end
    idle();
  endtask

  // Always-taken on one IP: local history walks 0,1,3,..,63, so counters are fresh
  // until the history saturates; the 8th fetch hits the local counter trained once.
  task automatic test_train();
    reset_init();
    for (int k = 1; k <= 8; k++) begin
      IP_f = 16'h0040; fetch_valid = 1;
      @(negedge CLOCK_50);
      checks++; if (prediction !== (k == 8)) begin errors++; $display("FAIL train_pred[%0d]: got %b want %b", k, prediction, k == 8); end
      tick(); fetch_valid = 0; resolve_valid = 1; resolve_didJump = 1;
      tick(); resolve_valid = 0;
      checks++; if (mispredict !== (k < 8)) begin errors++; $display("FAIL train_mis[%0d]: got %b want %b", k, mispredict, k < 8); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL train_count[%0d]: got %0d want 0", k, count); end
    end
    tick();
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL train_pulse: got %b want 0", mispredict); end
    idle();
  endtask

  task automatic test_full();
    reset_init();
    for (int i = 0; i < 4; i++) begin IP_f = 16'h0010 + 16'(i); fetch_valid = 1; tick(); end
    checks++; if (count !== 3'd4)       begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", fetch_stall); end
    IP_f = 16'h0014; tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_5th: got %0d want 4", count); end
    // Resolve while full: the stall is based on pre-pop occupancy, so the fetch is dropped
    IP_f = 16'h0015; resolve_valid = 1; resolve_didJump = 0; tick();
    checks++; if (count !== 3'd3)      begin errors++; $display("FAIL full_res_fetch: got %0d want 3", count); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL full_res_mis: got %b want 0", mispredict); end
    tick();
    checks++; if (count !== 3'd3)      begin errors++; $display("FAIL b2b_count: got %0d want 3", count); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL b2b_mis: got %b want 0", mispredict); end
    fetch_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    resolve_valid = 0;
    checks++; if (count !== 3'd0)      begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL drain_mis: got %b want 0", mispredict); end
    idle();
  endtask

  task automatic test_mispredict();
    reset_init();
    for (int i = 0; i < 3; i++) begin
      IP_f = 16'h0020 + 16'(i); fetch_valid = 1;
      @(negedge CLOCK_50);
      checks++; if (prediction !== 1'b0) begin errors++; $display("FAIL mis_pred[%0d]: got %b want 0", i, prediction); end
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mis_count3: got %0d want 3", count); end
    IP_f = 16'h0023; resolve_valid = 1; resolve_didJump = 1; tick();
    idle();
    checks++; if (mispredict !== 1'b1)          begin errors++; $display("FAIL mis_pulse: got %b want 1", mispredict); end
    checks++; if (count !== 3'd0)               begin errors++; $display("FAIL mis_clear: got %0d want 0", count); end
    checks++; if (dut.spec_ghr_q !== 12'h001)   begin errors++; $display("FAIL mis_spec_ghr: got %h want 001", dut.spec_ghr_q); end
    checks++; if (dut.com_ghr_q !== 12'h001)    begin errors++; $display("FAIL mis_com_ghr: got %h want 001", dut.com_ghr_q); end
    tick();
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", mispredict); end
  endtask

  task automatic test_flush();
    reset_init();
    IP_f = 16'h0020; fetch_valid = 1; tick();
    fetch_valid = 0; resolve_valid = 1; resolve_didJump = 1; tick();
    resolve_valid = 0; fetch_valid = 1;
    IP_f = 16'h0021; tick();
    IP_f = 16'h0022; tick();
    checks++; if (dut.spec_ghr_q !== 12'h004) begin errors++; $display("FAIL flush_spec_pre: got %h want 004", dut.spec_ghr_q); end
    IP_f = 16'h0023; flush = 1; resolve_valid = 1; resolve_didJump = 0; tick();
    flush = 0; resolve_valid = 0; fetch_valid = 0;
    checks++; if (count !== 3'd0)             begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (mispredict !== 1'b0)        begin errors++; $display("FAIL flush_mis: got %b want 0", mispredict); end
    checks++; if (dut.spec_ghr_q !== 12'h002) begin errors++; $display("FAIL flush_spec: got %h want 002", dut.spec_ghr_q); end
    checks++; if (dut.com_ghr_q !== 12'h002)  begin errors++; $display("FAIL flush_com: got %h want 002", dut.com_ghr_q); end
    IP_f = 16'h0024; fetch_valid = 1; tick();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_after_fetch: got %0d want 1", count); end
    idle();
  endtask

  task automatic test_alternating();
    logic exp;
    reset_init();
    for (int i = 0; i < 28; i++) begin
      exp = (i % 2 == 0);
      IP_f = 16'h0040; fetch_valid = 1;
      @(negedge CLOCK_50);
      if (i >= 20) begin
        checks++; if (prediction !== exp) begin errors++; $display("FAIL alt_pred[%0d]: got %b want %b", i, prediction, exp); end
      end
      tick(); fetch_valid = 0; resolve_valid = 1; resolve_didJump = exp;
      tick(); resolve_valid = 0;
      if (i >= 20) begin
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL alt_mis[%0d]: got %b want 0", i, mispredict); end
      end
    end
    idle();
  endtask

  task automatic test_resolve_err();
    reset_init();
    resolve_valid = 1; resolve_didJump = 1; tick();
    resolve_valid = 0;
    checks++; if (resolve_err !== 1'b1)      begin errors++; $display("FAIL err_pulse: got %b want 1", resolve_err); end
    checks++; if (count !== 3'd0)            begin errors++; $display("FAIL err_count: got %0d want 0", count); end
    checks++; if (mispredict !== 1'b0)       begin errors++; $display("FAIL err_mis: got %b want 0", mispredict); end
    tick();
    checks++; if (resolve_err !== 1'b0)      begin errors++; $display("FAIL err_one_cycle: got %b want 0", resolve_err); end
    checks++; if (dut.com_ghr_q !== 12'h000) begin errors++; $display("FAIL err_com_ghr: got %h want 000", dut.com_ghr_q); end
    IP_f = 16'h0040; #1;
    checks++; if (prediction !== 1'b0)       begin errors++; $display("FAIL err_refetch: got %b want 0", prediction); end
    idle();
  endtask

  initial begin
    idle(); RESET_N = 1;
    test_reset();
    test_reset_mid_init();
    test_train();
    test_full();
    test_mispredict();
    test_flush();
    test_alternating();
    test_resolve_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
